// File: rtl/irq_priority_resolver.sv
// Interrupt priority resolver: request/in-service registers,
// fixed or rotating priority, and an ack/vector handshake.
module irq_priority_resolver #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  input  logic                 rotate_mode,
  input  logic                 ack,
  input  logic                 eoi,
  input  logic                 eoi_specific,
  input  logic [$clog2(N)-1:0] eoi_level,
  output logic                 int_out,
  output logic                 vec_valid,
  output logic [$clog2(N)-1:0] vec,
  output logic                 spurious,
  output logic [N-1:0]         isr
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HOLD
  } state_t;

  state_t state, state_d;

  logic [N-1:0] irr;
  logic [W-1:0] lp, lp_d;
  logic [N-1:0] pend_req;

  logic         cand_hit, isr_hit;
  logic [W-1:0] cand_idx, isr_idx;
  logic [W-1:0] cand_rank, isr_rank;
  logic [W-1:0] ch;
  logic         winner;

  logic         int_out_d, vec_valid_d, spurious_d;
  logic [W-1:0] vec_d;
  logic [N-1:0] ack_set, eoi_clear;
  logic         eoi_hit, level_ok;
  logic [W-1:0] eoi_ch;

  assign pend_req = irr & ~mask;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    cand_hit  = 1'b0;
    cand_idx  = '0;
    cand_rank = '0;
    isr_hit   = 1'b0;
    isr_idx   = '0;
    isr_rank  = '0;
    ch        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      ch = W'((int'(lp) + 1 + k) % N);
      if (pend_req[ch]) begin
        cand_hit  = 1'b1;
        cand_idx  = ch;
        cand_rank = W'(k);
      end
      if (isr[ch]) begin
        isr_hit  = 1'b1;
        isr_idx  = ch;
        isr_rank = W'(k);
      end
    end
  end

  assign winner = cand_hit &&
                  (!isr_hit || (cand_rank < isr_rank));

  assign level_ok = ({{(32-W){1'b0}}, eoi_level} < 32'(N));

  always_comb begin
    eoi_hit   = 1'b0;
    eoi_ch    = '0;
    eoi_clear = '0;
    if (eoi) begin
      if (eoi_specific) begin
        if (level_ok && isr[eoi_level]) begin
          eoi_hit = 1'b1;
          eoi_ch  = eoi_level;
        end
      end else if (isr_hit) begin
        eoi_hit = 1'b1;
        eoi_ch  = isr_idx;
      end
    end
    if (eoi_hit) eoi_clear[eoi_ch] = 1'b1;
  end

  always_comb begin
    if (!rotate_mode) lp_d = W'(N - 1);
    else if (eoi_hit) lp_d = eoi_ch;
    else              lp_d = lp;
  end

  always_comb begin
    state_d     = state;
    int_out_d   = int_out;
    vec_valid_d = 1'b0;
    vec_d       = vec;
    spurious_d  = spurious;
    ack_set     = '0;
    unique case (state)
      IDLE: begin
        if (winner) begin
          int_out_d = 1'b1;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (ack) begin
          state_d     = HOLD;
          int_out_d   = 1'b0;
          vec_valid_d = 1'b1;
          if (winner) begin
            vec_d            = cand_idx;
            spurious_d       = 1'b0;
            ack_set[cand_idx] = 1'b1;
          end else begin
            vec_d      = W'(N - 1);
            spurious_d = 1'b1;
          end
        end else if (!winner) begin
          int_out_d = 1'b0;
          state_d   = IDLE;
        end
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irr       <= '0;
      isr       <= '0;
      lp        <= W'(N - 1);
      int_out   <= 1'b0;
      vec_valid <= 1'b0;
      vec       <= '0;
      spurious  <= 1'b0;
    end else begin
      state     <= state_d;
      irr       <= req & ~ack_set;
      isr       <= (isr & ~eoi_clear) | ack_set;
      lp        <= lp_d;
      int_out   <= int_out_d;
      vec_valid <= vec_valid_d;
      vec       <= vec_d;
      spurious  <= spurious_d;
    end
  end

endmodule

// File: tb/tb_irq_priority_resolver.sv
// Directed bench for irq_priority_resolver (N=8).
// Linear stimulus with hand-computed expectations.
module tb_irq_priority_resolver;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       rotate_mode;
  logic       ack;
  logic       eoi;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic       vec_valid;
  logic [2:0] vec;
  logic       spurious;
  logic [7:0] isr;

  int tests;
  int fails;

  irq_priority_resolver #(.N(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .mask(mask),
    .rotate_mode(rotate_mode),
    .ack(ack),
    .eoi(eoi),
    .eoi_specific(eoi_specific),
    .eoi_level(eoi_level),
    .int_out(int_out),
    .vec_valid(vec_valid),
    .vec(vec),
    .spurious(spurious),
    .isr(isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse_eoi(input logic spec,
                           input logic [2:0] lvl);
    eoi          = 1'b1;
    eoi_specific = spec;
    eoi_level    = lvl;
    tick();
    eoi          = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = '0;
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    req          = '0;
    mask         = '0;
    rotate_mode  = 1'b0;
    ack          = 1'b0;
    eoi          = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = '0;
    tick();
    tick();
    chk("rst_int", 32'(int_out), 32'd0);
    chk("rst_vv", 32'(vec_valid), 32'd0);
    chk("rst_vec", 32'(vec), 32'd0);
    chk("rst_sp", 32'(spurious), 32'd0);
    chk("rst_isr", 32'(isr), 32'h00);
    rst_n = 1'b1;
    tick();

    // fixed priority, channels 3 and 5
    req = 8'h28;
    tick();
    chk("t1_lat1", 32'(int_out), 32'd0);
    tick();
    chk("t1_int", 32'(int_out), 32'd1);
    pulse_ack();
    chk("t1_vv", 32'(vec_valid), 32'd1);
    chk("t1_vec", 32'(vec), 32'd3);
    chk("t1_isr", 32'(isr), 32'h08);
    chk("t1_sp", 32'(spurious), 32'd0);
    chk("t1_intlo", 32'(int_out), 32'd0);
    tick();
    chk("t1_vvlo", 32'(vec_valid), 32'd0);
    chk("t1_hold", 32'(vec), 32'd3);

    // lower request blocked by in-service channel 3
    req = 8'h80;
    tick();
    tick();
    tick();
    chk("t2_block", 32'(int_out), 32'd0);
    pulse_eoi(1'b0, 3'd0);
    chk("t2_eoi", 32'(isr), 32'h00);
    tick();
    chk("t2_int", 32'(int_out), 32'd1);
    pulse_ack();
    chk("t2_vec", 32'(vec), 32'd7);
    chk("t2_isr", 32'(isr), 32'h80);
    req = 8'h00;
    tick();
    pulse_eoi(1'b0, 3'd0);
    chk("t2_clr", 32'(isr), 32'h00);

    // rotation: service 2, EOI moves lp to 2
    rotate_mode = 1'b1;
    req = 8'h04;
    tick();
    tick();
    chk("t3_int", 32'(int_out), 32'd1);
    pulse_ack();
    chk("t3_vec2", 32'(vec), 32'd2);
    chk("t3_isr", 32'(isr), 32'h04);
    req = 8'h00;
    tick();
    pulse_eoi(1'b0, 3'd0);
    chk("t3_eoi", 32'(isr), 32'h00);
    req = 8'h05;
    tick();
    tick();
    chk("t3_int2", 32'(int_out), 32'd1);
    pulse_ack();
    chk("t3_vec0", 32'(vec), 32'd0);
    chk("t3_isr0", 32'(isr), 32'h01);
    req = 8'h00;
    tick();
    pulse_eoi(1'b1, 3'd0);
    chk("t3_spec", 32'(isr), 32'h00);
    rotate_mode = 1'b0;
    tick();

    // request withdrawn before ack -> spurious
    req = 8'h10;
    tick();
    tick();
    chk("t4_int", 32'(int_out), 32'd1);
    req = 8'h00;
    tick();
    chk("t4_pend", 32'(int_out), 32'd1);
    pulse_ack();
    chk("t4_vv", 32'(vec_valid), 32'd1);
    chk("t4_vec", 32'(vec), 32'd7);
    chk("t4_sp", 32'(spurious), 32'd1);
    chk("t4_isr", 32'(isr), 32'h00);
    chk("t4_intlo", 32'(int_out), 32'd0);
    tick();
    chk("t4_vvlo", 32'(vec_valid), 32'd0);

    // fully masked, then unmasked (lp back to 7 -> ch0)
    mask = 8'hFF;
    req  = 8'hFF;
    tick();
    tick();
    tick();
    tick();
    chk("t5_mask", 32'(int_out), 32'd0);
    mask = 8'h00;
    tick();
    chk("t5_int", 32'(int_out), 32'd1);
    pulse_ack();
    chk("t5_vec", 32'(vec), 32'd0);
    chk("t5_sp", 32'(spurious), 32'd0);
    chk("t5_isr", 32'(isr), 32'h01);
    req = 8'h00;
    tick();
    pulse_eoi(1'b0, 3'd0);
    chk("t5_clr", 32'(isr), 32'h00);

    // put channel 4 in service
    req = 8'h10;
    tick();
    tick();
    pulse_ack();
    chk("t6_isr4", 32'(isr), 32'h10);
    req = 8'h00;
    tick();

    // ack of channel 1 together with specific EOI of 4
    req = 8'h02;
    tick();
    tick();
    chk("t6_int", 32'(int_out), 32'd1);
    ack          = 1'b1;
    eoi          = 1'b1;
    eoi_specific = 1'b1;
    eoi_level    = 3'd4;
    tick();
    ack          = 1'b0;
    eoi          = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = '0;
    chk("t6_isr", 32'(isr), 32'h02);
    chk("t6_vec", 32'(vec), 32'd1);
    req = 8'h00;
    tick();

    // async reset while pending
    req = 8'h01;
    tick();
    tick();
    chk("t7_int", 32'(int_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_int0", 32'(int_out), 32'd0);
    chk("t7_vec0", 32'(vec), 32'd0);
    chk("t7_vv0", 32'(vec_valid), 32'd0);
    chk("t7_isr0", 32'(isr), 32'h00);
    chk("t7_sp0", 32'(spurious), 32'd0);
    req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
